// File: rtl/render_sched_pkg.sv
// render_sched_pkg: shared rectangle command layout constants and helpers
package render_sched_pkg;
  localparam int X_BITES = 10;
  localparam int Y_BITES = 10;
  localparam int COLOR_BITES = 8;
  localparam int RECT_CMD_BITS = 2 * X_BITES + 2 * Y_BITES + 2 * COLOR_BITES + 1;
  localparam int OFF_BORDER_COLOR = 0;
  localparam int OFF_BORDER = OFF_BORDER_COLOR + COLOR_BITES;
  localparam int OFF_BACK_COLOR = OFF_BORDER + 1;
  localparam int OFF_HEIGHT = OFF_BACK_COLOR + COLOR_BITES;
  localparam int OFF_WIDTH = OFF_HEIGHT + Y_BITES;
  localparam int OFF_ORIGIN_Y = OFF_WIDTH + X_BITES;
  localparam int OFF_ORIGIN_X = OFF_ORIGIN_Y + Y_BITES;
  function automatic logic is_empty(input logic [RECT_CMD_BITS-1:0] c);
    return c[OFF_WIDTH +: X_BITES] == '0 || c[OFF_HEIGHT +: Y_BITES] == '0;
  endfunction
endpackage

// File: rtl/render_sched_if.sv
// render_sched_if: requester, renderer and completion signals of the scheduler
interface render_sched_if #(parameter int NUM_REQ = 4);
  import render_sched_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*RECT_CMD_BITS-1:0] req_cmd;
  logic [NUM_REQ-1:0] req_ready;
  logic rr_enable;
  logic [X_BITES-1:0] rr_origin_x;
  logic [X_BITES-1:0] rr_width;
  logic [Y_BITES-1:0] rr_origin_y;
  logic [Y_BITES-1:0] rr_height;
  logic [COLOR_BITES-1:0] rr_back_color;
  logic [COLOR_BITES-1:0] rr_border_color;
  logic rr_border;
  logic rr_done;
  logic cmpl_valid;
  logic [IW-1:0] cmpl_id;
  logic busy;
  modport master (
    output req_valid, req_cmd, rr_done,
    input req_ready, rr_enable, rr_origin_x, rr_width, rr_origin_y, rr_height,
    input rr_back_color, rr_border_color, rr_border, cmpl_valid, cmpl_id, busy
  );
  modport slave (
    input req_valid, req_cmd, rr_done,
    output req_ready, rr_enable, rr_origin_x, rr_width, rr_origin_y, rr_height,
    output rr_back_color, rr_border_color, rr_border, cmpl_valid, cmpl_id, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from last_grant+1 with wrap
module rr_arbiter #(parameter int N = 4) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant
);
  localparam int W = $clog2(N);
  logic [W-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last_grant) + i) % N);
      if (grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/render_sched.sv
// render_sched: round-robin scheduler feeding rectangle commands to one renderer
module render_sched import render_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ARM_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  render_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] ARM = 3'd2;
  localparam logic [2:0] DRAW = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  logic [2:0] state;
  logic [IW-1:0] last_grant, gidx, id;
  logic [NUM_REQ-1:0] grant;
  logic [RECT_CMD_BITS-1:0] sel, cmd;
  logic [AW-1:0] arm_cnt;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(bus.req_valid), .last_grant(last_grant), .grant(grant));
  always_comb begin
    gidx = '0;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        gidx = IW'(i);
        sel = bus.req_cmd[i*RECT_CMD_BITS +: RECT_CMD_BITS];
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      id <= '0;
      cmd <= '0;
      arm_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          last_grant <= gidx;
          id <= gidx;
          cmd <= sel;
          state <= is_empty(sel) ? RELEASE : LAUNCH;
        end
        LAUNCH: begin
          arm_cnt <= '0;
          state <= ARM;
        end
        ARM: begin
          arm_cnt <= arm_cnt + 1'b1;
          if (arm_cnt == AW'(ARM_CYCLES - 1)) state <= DRAW;
        end
        DRAW: if (bus.rr_done) state <= RELEASE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = (state == IDLE && !reset) ? grant : '0;
  assign bus.rr_enable = state == LAUNCH || state == ARM || state == DRAW;
  assign bus.busy = state != IDLE;
  assign bus.cmpl_valid = state == RELEASE;
  assign bus.cmpl_id = id;
  assign bus.rr_origin_x = cmd[OFF_ORIGIN_X +: X_BITES];
  assign bus.rr_origin_y = cmd[OFF_ORIGIN_Y +: Y_BITES];
  assign bus.rr_width = cmd[OFF_WIDTH +: X_BITES];
  assign bus.rr_height = cmd[OFF_HEIGHT +: Y_BITES];
  assign bus.rr_back_color = cmd[OFF_BACK_COLOR +: COLOR_BITES];
  assign bus.rr_border = cmd[OFF_BORDER];
  assign bus.rr_border_color = cmd[OFF_BORDER_COLOR +: COLOR_BITES];
endmodule
